// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: in-order queue of fetch predictions checked against execute outcomes;
// raises flush/redirect on a mispredict and feeds BHT updates. Optional counters: `BRU_STATS_EN.
module branch_resolution_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fq_push,
    input  logic [PC_W-1:0]  fq_pc,
    input  logic             fq_pred,
    input  logic [PC_W-1:0]  fq_target,
    output logic             fq_full,
    input  logic             ex_resolve,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             ex_err,
    output logic             upd_branch,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic             flush,
`ifdef BRU_STATS_EN
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`else
    output logic [PC_W-1:0]  redirect_pc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CQ_W  = $clog2(DEPTH + 1);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic              in_run;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CQ_W-1:0]   count_q, count_d;
    logic [PC_W-1:0]   pc_mem  [DEPTH];
    logic [PC_W-1:0]   tgt_mem [DEPTH];
    logic              pred_mem[DEPTH];

    logic [PC_W-1:0]   head_pc, head_tgt, redirect_d;
    logic              head_pred;
    logic              do_resolve, bad_resolve, mis, do_push;

    logic              upd_branch_p1, upd_taken_p1, flush_p1, ex_err_p1;
    logic [PC_W-1:0]   upd_pc_p1, redirect_p1;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM: next state; RECOVER is a single-cycle shadow of the flush pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mis) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_run = (state_q == RUN);
    end

    assign head_pc   = pc_mem[rd_ptr_q];
    assign head_tgt  = tgt_mem[rd_ptr_q];
    assign head_pred = pred_mem[rd_ptr_q];
    assign fq_full   = (count_q == CQ_W'(DEPTH));

    always_comb begin
        do_resolve  = in_run && ex_resolve && (count_q != '0);
        bad_resolve = in_run && ex_resolve && (count_q == '0);
        mis         = do_resolve && ((head_pred != ex_taken) ||
                                     (ex_taken && (ex_target != head_tgt)));
        // A full queue only makes room when the head retires cleanly this cycle
        do_push     = in_run && fq_push && !mis && (!fq_full || do_resolve);
        redirect_d  = ex_taken ? ex_target : head_pc + PC_W'(1);
        count_d     = count_q;
        if (do_push && !do_resolve)      count_d = count_q + CQ_W'(1);
        else if (!do_push && do_resolve) count_d = count_q - CQ_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (mis) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_resolve) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]   <= fq_pc;
            tgt_mem[wr_ptr_q]  <= fq_target;
            pred_mem[wr_ptr_q] <= fq_pred;
        end
    end

    // Stage p1: registered resolve results, one cycle after the resolve edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_branch_p1 <= 1'b0;
            upd_taken_p1  <= 1'b0;
            upd_pc_p1     <= '0;
            flush_p1      <= 1'b0;
            ex_err_p1     <= 1'b0;
            redirect_p1   <= '0;
        end else begin
            upd_branch_p1 <= do_resolve;
            flush_p1      <= mis;
            ex_err_p1     <= bad_resolve;
            if (do_resolve) begin
                upd_pc_p1    <= head_pc;
                upd_taken_p1 <= ex_taken;
            end
            if (mis) redirect_p1 <= redirect_d;
        end
    end

    assign upd_branch  = upd_branch_p1;
    assign upd_pc      = upd_pc_p1;
    assign upd_taken   = upd_taken_p1;
    assign flush       = flush_p1;
    assign ex_err      = ex_err_p1;
    assign redirect_pc = redirect_p1;

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (do_resolve) branch_cnt  <= sat_inc(branch_cnt);
            if (mis)        mispred_cnt <= sat_inc(mispred_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: queue-based reference model, directed
// scenarios followed by randomized traffic; build with BRU_STATS_EN to cover the counters.
module tb_branch_resolution_unit;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 8;
    localparam int TCNT_W = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            fq_push = 1'b0, fq_pred = 1'b0, ex_resolve = 1'b0, ex_taken = 1'b0;
    logic [PC_W-1:0] fq_pc = '0, fq_target = '0, ex_target = '0;
    logic            fq_full, ex_err, upd_branch, upd_taken, flush;
    logic [PC_W-1:0] upd_pc, redirect_pc;
`ifdef BRU_STATS_EN
    logic [TCNT_W-1:0] branch_cnt, mispred_cnt;
`endif

`ifdef BRU_STATS_EN
    branch_resolution_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(TCNT_W)) dut (
`else
    branch_resolution_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
`endif
        .clk(clk), .reset(reset),
        .fq_push(fq_push), .fq_pc(fq_pc), .fq_pred(fq_pred), .fq_target(fq_target),
        .fq_full(fq_full),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_err(ex_err), .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush(flush),
`ifdef BRU_STATS_EN
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
`else
        .redirect_pc(redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] tgt;
    } ent_t;

    typedef struct {
        int              stamp;
        bit              upd;
        logic [PC_W-1:0] pc;
        bit              taken;
        bit              fl;
        logic [PC_W-1:0] rd;
        bit              err;
        int              bc;
        int              mc;
    } ev_t;

    ent_t mq[$];
    ev_t  exp_q[$];
    bit   m_recover = 0;
    int   m_bc = 0, m_mc = 0;
    int   cyc = 0;
    int   checks = 0, failures = 0;
    logic [PC_W-1:0] mon_redir = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << TCNT_W) - 1) ? (1 << TCNT_W) - 1 : v + 1;
    endfunction

    // One cycle of stimulus; the model decides what the DUT must show a cycle later.
    task automatic drive(input bit push, input logic [PC_W-1:0] pc, input bit pred,
                         input logic [PC_W-1:0] tgt, input bit res, input bit tk,
                         input logic [PC_W-1:0] xtgt);
        ev_t  e;
        ent_t h;
        bit   full, resolved, mis;
        @(posedge clk);
        #1;
        chk("fq_full", fq_full, mq.size() == DEPTH);
        fq_push = push; fq_pc = pc; fq_pred = pred; fq_target = tgt;
        ex_resolve = res; ex_taken = tk; ex_target = xtgt;
        e = '{stamp: cyc + 1, upd: 0, pc: 0, taken: 0, fl: 0, rd: 0, err: 0, bc: 0, mc: 0};
        if (m_recover) begin
            m_recover = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        resolved = 0;
        mis = 0;
        if (res && mq.size() == 0) begin
            e.err = 1;
        end else if (res) begin
            h = mq.pop_front();
            resolved = 1;
            mis = (h.pred != tk) || (tk && xtgt != h.tgt);
            e.upd = 1; e.pc = h.pc; e.taken = tk; e.fl = mis;
            e.rd = tk ? xtgt : PC_W'(h.pc + 1);
            m_bc = sat(m_bc);
            if (mis) begin
                m_mc = sat(m_mc);
                mq.delete();
                m_recover = 1;
            end
        end
        if (push && !mis && (!full || resolved)) mq.push_back('{pc: pc, pred: pred, tgt: tgt});
        e.bc = m_bc; e.mc = m_mc;
        if (e.upd || e.err) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        fq_push = 0; ex_resolve = 0;
        #1;
        chk("rst_upd_branch", upd_branch, 0);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_upd_taken", upd_taken, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_ex_err", ex_err, 0);
        chk("rst_fq_full", fq_full, 0);
`ifdef BRU_STATS_EN
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispred_cnt", mispred_cnt, 0);
`endif
        mq.delete(); exp_q.delete();
        m_recover = 0; m_bc = 0; m_mc = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard when an event is due, flags any unexpected pulse.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            mon_redir = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                e = exp_q.pop_front();
                chk("upd_branch", upd_branch, e.upd);
                chk("ex_err", ex_err, e.err);
                chk("flush", flush, e.fl);
                if (e.upd) begin
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_taken", upd_taken, e.taken);
`ifdef BRU_STATS_EN
                    chk("branch_cnt", branch_cnt, e.bc);
                    chk("mispred_cnt", mispred_cnt, e.mc);
`endif
                end
                if (e.fl) mon_redir = e.rd;
            end else if (upd_branch || flush || ex_err) begin
                chk("spurious_pulse", {upd_branch, flush, ex_err}, 0);
            end
            chk("redirect_pc", redirect_pc, mon_redir);
        end
    end

    initial begin
        ent_t h;
        bit   pr, tk, ps, rs;
        logic [PC_W-1:0] xt;
        #12;
        chk("init_flush", flush, 0);
        chk("init_fq_full", fq_full, 0);
        reset = 1'b1;
        // Correct taken prediction
        drive(1, 8'h10, 1, 8'h20, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 8'h20);
        idle(2);
        // Mispredict squashes younger entry, push in RECOVER dropped, then empty resolve errors
        drive(1, 8'h30, 1, 8'h40, 0, 0, 0);
        drive(1, 8'h34, 0, 8'h00, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        drive(1, 8'h38, 0, 8'h00, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Full queue: lone push dropped, push with clean resolve accepted
        for (int i = 0; i < 4; i++) drive(1, PC_W'(8'h50 + i), 0, 8'h00, 0, 0, 0);
        drive(1, 8'h5A, 0, 8'h00, 0, 0, 0);
        drive(1, 8'h5B, 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // PC wrap on not-taken recovery, then wrong target on a taken branch
        drive(1, 8'hFF, 1, 8'h05, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        drive(1, 8'h60, 1, 8'h05, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 8'h07);
        idle(2);
        // Ten resolves, three of them mispredicted
        for (int i = 0; i < 10; i++) begin
            drive(1, PC_W'(8'h70 + i), 1, 8'h90, 0, 0, 0);
            drive(0, 0, 0, 0, 1, (i % 3 != 0) || (i == 9), 8'h90);
            idle(1);
        end
        // Reset in the middle of traffic, queue must be empty afterwards
        drive(1, 8'hA0, 0, 0, 0, 0, 0);
        drive(1, 8'hA4, 0, 0, 0, 0, 0);
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ps = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 9) < 4);
            pr = $urandom_range(0, 1);
            tk = 0; xt = PC_W'($urandom);
            if (mq.size() > 0) begin
                h = mq[0];
                tk = ($urandom_range(0, 5) == 0) ? !h.pred : h.pred;
                if ($urandom_range(0, 4) != 0) xt = h.tgt;
            end
            drive(ps, PC_W'($urandom), pr, PC_W'($urandom), rs, tk, xt);
            if (i == 300) do_reset();
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
